// File: rtl/udp_pkt_buf_reader.sv
// ---------------------------------------------------------------------------
// udp_pkt_buf_reader
//
// Read side of the UDP transmit packet buffer. The writer stores complete
// frames into port A of a 2**ADDR_WIDTH x 9 dual-port RAM and pulses
// frame_commit once per frame. This block counts committed frames, fetches
// their bytes through RAM port B (1-cycle read latency, unregistered output)
// and streams them downstream as a valid/ready byte stream with a last flag.
// Word format: bit[8] = end-of-frame, bits[7:0] = payload byte.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   frame_commit    one-cycle pulse: one more complete frame is in RAM
//   ram_addrb       RAM port B read address
//   ram_ceb         RAM port B read strobe
//   ram_dob         RAM port B read data, valid the cycle after ram_ceb
//   tx_data/tx_last/tx_valid/tx_ready   downstream byte stream
//   rd_ptr          address after the last byte accepted downstream
//   frames_pending  committed frames not yet fully sent
//   commit_ovf      one-cycle pulse: a commit was dropped (counter saturated)
// ---------------------------------------------------------------------------
module udp_pkt_buf_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int FCNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_commit,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_ceb,
  input  logic [8:0]            ram_dob,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [FCNT_WIDTH-1:0] frames_pending,
  output logic                  commit_ovf
);

  localparam logic [FCNT_WIDTH-1:0] FCNT_MAX  = '1;
  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE  = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // FSM / fetch side
  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   fptr_q;       // next address to read
  logic                    infl_q;       // a read issued last cycle returns now
  logic [ADDR_WIDTH-1:0]   infl_addr_q;  // address of that in-flight read

  // Frame counter and read pointer
  logic [FCNT_WIDTH-1:0]   fcnt_q, fcnt_d;
  logic                    ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0]   rdptr_q, rdptr_d;

  // Two-entry output stage: output register plus skid register
  logic                    out_v_q, out_v_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    skid_v_q, skid_v_d;
  logic [7:0]              skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;

  logic                    hs;
  logic                    last_hs;
  logic                    arrive;
  logic                    eof_arrive;
  logic [1:0]              occ;
  logic                    issue;

  assign hs         = out_v_q & tx_ready;
  assign last_hs    = hs & out_last_q;
  assign arrive     = infl_q;
  assign eof_arrive = infl_q & ram_dob[8];

  // Buffered entries plus the read in flight. A byte leaving this cycle
  // frees its slot for a read issued in the same cycle, which is what keeps
  // one byte per cycle flowing with only two entries of storage.
  assign occ   = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, infl_q};
  assign issue = (state_q == FETCH) && ((occ - {1'b0, hs}) < 2'd2);

  assign ram_ceb   = issue;
  assign ram_addrb = fptr_q;

  assign tx_valid       = out_v_q;
  assign tx_data        = out_data_q;
  assign tx_last        = out_last_q;
  assign rd_ptr         = rdptr_q;
  assign frames_pending = fcnt_q;
  assign commit_ovf     = ovf_q;

  // ---------------------------------------------------------------------
  // Frame counter: commit and last-byte handshake in the same cycle cancel.
  // A commit at saturation is dropped and flagged.
  // ---------------------------------------------------------------------
  always_comb begin
    fcnt_d = fcnt_q;
    ovf_d  = 1'b0;
    if (frame_commit && !last_hs) begin
      if (fcnt_q == FCNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FCNT_ONE;
      end
    end else if (!frame_commit && last_hs) begin
      fcnt_d = fcnt_q - FCNT_ONE;
    end
  end

  // rd_ptr only moves on accepted bytes, never on fetched ones.
  assign rdptr_d = hs ? (rdptr_q + ADDR_ONE) : rdptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      rdptr_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      rdptr_q <= rdptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage. Returning RAM data lands in the output register when it
  // is (or is becoming) free, otherwise in the skid register. The issue
  // rule above guarantees the skid register is free whenever it is needed.
  // ---------------------------------------------------------------------
  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (hs) begin
      if (skid_v_q) begin
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_v_d   = arrive;
        if (arrive) begin
          skid_data_d = ram_dob[7:0];
          skid_last_d = ram_dob[8];
        end
      end else if (arrive) begin
        out_data_d = ram_dob[7:0];
        out_last_d = ram_dob[8];
      end else begin
        out_v_d    = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (arrive) begin
      if (!out_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = ram_dob[7:0];
        out_last_d = ram_dob[8];
      end else begin
        skid_v_d    = 1'b1;
        skid_data_d = ram_dob[7:0];
        skid_last_d = ram_dob[8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM. Reads are issued speculatively; the one issued in the cycle
  // the end-of-frame word returns is dropped by not marking it in flight,
  // and the fetch pointer is rewound to just past the end-of-frame word.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fptr_q      <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          infl_q <= 1'b0;
          if (fcnt_q != '0) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          infl_q <= issue & ~eof_arrive;
          if (issue) begin
            infl_addr_q <= fptr_q;
            fptr_q      <= fptr_q + ADDR_ONE;
          end
          if (eof_arrive) begin
            fptr_q  <= infl_addr_q + ADDR_ONE;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          infl_q <= 1'b0;
          if (last_hs) begin
            state_q <= (fcnt_d != '0) ? FETCH : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          infl_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_pkt_buf_reader.sv
module tb_udp_pkt_buf_reader;

  localparam int AW = 11;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_commit = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] ram_addrb;
  logic          ram_ceb;
  logic [8:0]    ram_dob = '0;
  logic [7:0]    tx_data;
  logic          tx_last;
  logic          tx_valid;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] frames_pending;
  logic          commit_ovf;

  logic [8:0] mem [0:2047];

  int checks = 0;
  int failures = 0;

  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  int stab_err;
  int occ_err;

  typedef struct {
    int commit; int ready; int ceb; int addr; int valid;
    int data;   int last;  int rd;  int pend;
  } vec_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  // RAM port B model: 1-cycle read latency
  always @(posedge clk) begin
    if (ram_ceb) ram_dob <= mem[ram_addrb];
  end

  udp_pkt_buf_reader #(.ADDR_WIDTH(AW), .FCNT_WIDTH(FW)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_commit   (frame_commit),
    .ram_addrb      (ram_addrb),
    .ram_ceb        (ram_ceb),
    .ram_dob        (ram_dob),
    .tx_data        (tx_data),
    .tx_last        (tx_last),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rd_ptr         (rd_ptr),
    .frames_pending (frames_pending),
    .commit_ovf     (commit_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame_commit = 1'b0;
  endtask

  task automatic load_frame4();
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h144;
    mem[4] = 9'h055;
  endtask

  // Runs up to maxcyc cycles, committing in the first ncommit cycles and
  // recording every accepted byte. Stops after stop_n bytes were accepted.
  task automatic collect(input int ncommit, input bit bp, input int maxcyc, input int stop_n);
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit         prev_v = 1'b0;
    bit         prev_rdy = 1'b1;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    int         iss = 0;
    int         acc = 0;
    q_data.delete(); q_last.delete(); q_cyc.delete();
    stab_err = 0; occ_err = 0;
    for (int c = 0; c < maxcyc; c++) begin
      frame_commit = (c < ncommit);
      tx_ready = bp ? pat[c % 4] : 1'b1;
      @(negedge clk);
      if (prev_v && !prev_rdy &&
          !(tx_valid === 1'b1 && tx_data === prev_d && tx_last === prev_l)) stab_err++;
      if (iss - acc > 2) occ_err++;
      if (ram_ceb === 1'b1) iss++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        acc++;
        q_data.push_back(int'(tx_data));
        q_last.push_back(int'(tx_last));
        q_cyc.push_back(c);
      end
      prev_v = tx_valid; prev_rdy = tx_ready; prev_d = tx_data; prev_l = tx_last;
      @(posedge clk); #1;
      if (q_data.size() >= stop_n) break;
    end
    frame_commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ceb_cnt;
    int bad;
    int exp_b [4];
    int wexp_d [4];
    int wexp_l [4];

    // cycle-by-cycle single frame: commit in cycle 0 (t)
    //          commit ready ceb addr valid data last rd pend
    vt[0] = '{1, 1, 0, 0, 0, 'h00, 0, 0, 0};
    vt[1] = '{0, 1, 0, 0, 0, 'h00, 0, 0, 1};
    vt[2] = '{0, 1, 1, 0, 0, 'h00, 0, 0, 1};
    vt[3] = '{0, 1, 1, 1, 0, 'h00, 0, 0, 1};
    vt[4] = '{0, 1, 1, 2, 1, 'h11, 0, 0, 1};
    vt[5] = '{0, 1, 1, 3, 1, 'h22, 0, 1, 1};
    vt[6] = '{0, 1, 1, 4, 1, 'h33, 0, 2, 1};
    vt[7] = '{0, 1, 0, 0, 1, 'h44, 1, 3, 1};
    vt[8] = '{0, 1, 0, 0, 0, 'h00, 0, 4, 0};
    vt[9] = '{0, 1, 0, 0, 0, 'h00, 0, 4, 0};
    exp_b  = '{'h11, 'h22, 'h33, 'h44};
    wexp_d = '{'hA1, 'hA2, 'hA3, 'hAA};
    wexp_l = '{0, 0, 1, 1};

    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;

    // ---- reset then idle
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_ram_ceb", 32'(ram_ceb), 0);
    chk("rst_ram_addrb", 32'(ram_addrb), 0);
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_pending", 32'(frames_pending), 0);
    chk("rst_ovf", 32'(commit_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready = 1'b1;
    ceb_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (ram_ceb !== 1'b0) ceb_cnt++;
    end
    chk("idle_ceb_count", ceb_cnt, 0);
    @(posedge clk); #1;

    // ---- single frame, table driven
    load_frame4();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      frame_commit = (vt[i].commit != 0);
      tx_ready = (vt[i].ready != 0);
      @(negedge clk);
      chk($sformatf("sf%0d_ceb", i), 32'(ram_ceb), vt[i].ceb);
      if (vt[i].ceb != 0) chk($sformatf("sf%0d_addr", i), 32'(ram_addrb), vt[i].addr);
      chk($sformatf("sf%0d_valid", i), 32'(tx_valid), vt[i].valid);
      if (vt[i].valid != 0) chk($sformatf("sf%0d_data", i), 32'(tx_data), vt[i].data);
      chk($sformatf("sf%0d_last", i), 32'(tx_last), vt[i].last);
      chk($sformatf("sf%0d_rd_ptr", i), 32'(rd_ptr), vt[i].rd);
      chk($sformatf("sf%0d_pending", i), 32'(frames_pending), vt[i].pend);
      @(posedge clk); #1;
    end
    frame_commit = 1'b0;

    // ---- backpressure
    do_reset();
    collect(1, 1'b1, 100, 4);
    chk("bp_count", q_data.size(), 4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk($sformatf("bp_data%0d", i), q_data[i], exp_b[i]);
      chk($sformatf("bp_last%0d", i), q_last[i], (i == 3) ? 1 : 0);
    end
    chk("bp_stable", stab_err, 0);
    chk("bp_occupancy", occ_err, 0);
    chk("bp_rd_ptr", 32'(rd_ptr), 4);
    chk("bp_pending", 32'(frames_pending), 0);

    // ---- wrap and back-to-back: filler frame moves rd_ptr to 2046
    tx_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 2045; i++) mem[i] = {1'b0, 8'(i)};
    mem[2045] = 9'h1FD;
    collect(1, 1'b0, 2300, 2046);
    chk("wrap_fill_count", q_data.size(), 2046);
    repeat (3) begin @(posedge clk); #1; end
    chk("wrap_fill_rd_ptr", 32'(rd_ptr), 2046);
    chk("wrap_fill_pending", 32'(frames_pending), 0);
    mem[2046] = 9'h0A1; mem[2047] = 9'h0A2; mem[0] = 9'h1A3; mem[1] = 9'h1AA;
    mem[2] = 9'h0EE;
    collect(2, 1'b0, 40, 4);
    chk("wrap_count", q_data.size(), 4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk($sformatf("wrap_data%0d", i), q_data[i], wexp_d[i]);
      chk($sformatf("wrap_last%0d", i), q_last[i], wexp_l[i]);
    end
    if (q_cyc.size() == 4) begin
      chk("wrap_contig1", q_cyc[1] - q_cyc[0], 1);
      chk("wrap_contig2", q_cyc[2] - q_cyc[1], 1);
      chk("wrap_gap_ok", (q_cyc[3] - q_cyc[2] <= 4) ? 1 : 0, 1);
    end
    collect(0, 1'b0, 10, 100);
    chk("wrap_no_extra", q_data.size(), 0);
    chk("wrap_rd_ptr", 32'(rd_ptr), 2);
    chk("wrap_pending", 32'(frames_pending), 0);

    // ---- counter saturation and simultaneous commit + last
    tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 2048; i++) mem[i] = {1'b1, 8'(i)};
    repeat (31) begin frame_commit = 1'b1; @(posedge clk); #1; end
    frame_commit = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("sat_pending31", 32'(frames_pending), 31);
    chk("sat_ovf_idle", 32'(commit_ovf), 0);
    chk("sat_held_valid", 32'(tx_valid), 1);
    chk("sat_held_last", 32'(tx_last), 1);
    chk("sat_held_data", 32'(tx_data), 0);
    @(posedge clk); #1;
    frame_commit = 1'b1;
    @(posedge clk); #1;
    frame_commit = 1'b0;
    @(negedge clk);
    chk("sat_ovf_pulse", 32'(commit_ovf), 1);
    chk("sat_pending_hold", 32'(frames_pending), 31);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_ovf_clear", 32'(commit_ovf), 0);
    @(posedge clk); #1;
    frame_commit = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("sim_last_beat", 32'(tx_valid & tx_last), 1);
    @(posedge clk); #1;
    frame_commit = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("sim_pending", 32'(frames_pending), 31);
    chk("sim_ovf", 32'(commit_ovf), 0);
    chk("sim_rd_ptr", 32'(rd_ptr), 1);
    @(posedge clk); #1;

    // ---- reset mid-frame
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    load_frame4();
    tx_ready = 1'b1;
    do_reset();
    collect(1, 1'b0, 50, 2);
    chk("rmid_accepted", q_data.size(), 2);
    chk("rmid_rd_ptr_pre", 32'(rd_ptr), 2);
    #1 rst = 1'b1;
    #1;
    chk("rmid_tx_valid", 32'(tx_valid), 0);
    chk("rmid_rd_ptr", 32'(rd_ptr), 0);
    chk("rmid_pending", 32'(frames_pending), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || ram_ceb !== 1'b0) bad++;
    end
    chk("rmid_quiet", bad, 0);
    @(posedge clk); #1;
    collect(1, 1'b0, 30, 4);
    chk("rmid_new_count", q_data.size(), 4);
    if (q_data.size() > 0) chk("rmid_new_first", q_data[0], 'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_pkt_buf_reader.md
Name: udp_pkt_buf_reader

Overview:
- Read side of the UDP transmit packet buffer: a 2048 x 9 dual-port RAM (port B owned by this block). Each word is bit[8] = end-of-frame marker and bits[7:0] = payload byte.
- The frame writer stores frames into port A and pulses frame_commit once per complete frame.
- This block tracks committed frames, fetches their bytes through the 1-cycle-latency (unregistered-output) RAM port, and streams them to the MAC/UDP TX path over a valid/ready byte stream with a last flag.
- It returns rd_ptr to the writer for free-space accounting.

Parameters:
- ADDR_WIDTH, 11, RAM address width; buffer depth = 2**ADDR_WIDTH bytes, addresses wrap modulo depth.
- FCNT_WIDTH, 5, width of the committed-frame counter; max outstanding frames = 2**FCNT_WIDTH-1.

Ports:
- clk  in  1  system clock; RAM port B clock is tied to the same clk.
- rst  in  1  asynchronous, active-high reset.
- frame_commit  in  1  one-cycle pulse from the writer: one more complete frame is in RAM.
- ram_addrb  out  ADDR_WIDTH  RAM port B read address.
- ram_ceb  out  1  RAM port B clock enable (read strobe); web is tied 0 externally.
- ram_dob  in  9  RAM port B read data, valid the cycle after ram_ceb.
- tx_data  out  8  stream byte.
- tx_last  out  1  final byte of the frame.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  downstream ready.
- rd_ptr  out  ADDR_WIDTH  address after the last byte accepted downstream.
- frames_pending  out  FCNT_WIDTH  committed frames not yet fully sent.
- commit_ovf  out  1  one-cycle pulse: frame_commit dropped because the counter was saturated.

Behaviour:
- Reset (async assert, sync release to first clk edge): ram_ceb=0, ram_addrb=0, tx_valid=0, tx_data=0, tx_last=0, rd_ptr=0, frames_pending=0, commit_ovf=0, FSM=IDLE, skid buffer empty, fetch pointer=0.
- Reset mid-frame discards the in-progress frame. No partial frame is resumed; the writer is reset by the same rst.
- Frame counter:
  - +1 on frame_commit.
  - -1 on the handshake (tx_valid && tx_ready) of a byte with tx_last=1.
  - Both in the same cycle: unchanged.
  - frame_commit while counter = max and no simultaneous decrement: counter holds, commit_ovf=1 for that cycle.
- Output stage: a 2-entry buffer (output register + skid register).
  - Handshake when tx_valid && tx_ready.
  - Once tx_valid=1, tx_data/tx_last hold stable until the handshake.
- FSM states:
  - IDLE: ram_ceb=0. Go to FETCH when frames_pending>0. The fetch pointer equals rd_ptr here.
  - FETCH:
    - Assert ram_ceb with ram_addrb=fetch pointer in any cycle where (buffered entries + reads in flight) < 2.
    - Fetch pointer increments (wrapping) per issued read.
    - On the cycle ram_dob returns with bit[8]=1: discard any read issued in the same cycle (its data is never buffered), set the fetch pointer to EOF address+1, go to DRAIN.
  - DRAIN: no reads; wait for the last-byte handshake. Then go to FETCH if frames_pending after decrement >0, else IDLE.
- Latency: frame committed with FSM in IDLE at cycle t → frames_pending=1 at t+1, first ram_ceb at t+2, tx_valid at t+4.
- Throughput: with tx_ready held 1, one byte per cycle within a frame.
- Back-to-back frames: at most a 3-cycle gap between a frame's last byte and the next frame's first byte.
- rd_ptr increments (mod 2**ADDR_WIDTH) on every handshake. It never counts fetched-but-unaccepted bytes.
- Address wrap: a frame spanning address 2047→0 streams contiguously without a bubble.
- A 1-byte frame (first word has bit[8]=1) is legal: tx_last=1 on the first beat.
- tx_ready low: at most 2 bytes are buffered and reads stop. Reads resume the cycle after space frees.

Test Plan:
- Reset then idle:
  - Stimulus: rst asserted mid-cycle, no commits.
  - Required: all outputs 0 immediately on assertion; ram_ceb stays 0 for 100 cycles.
- Single frame:
  - Stimulus: RAM preloaded 0x011,0x022,0x033,0x144 at addr 0..3; frame_commit at cycle t; tx_ready=1.
  - Required: tx_valid first at t+4; bytes 11,22,33,44 on consecutive cycles; tx_last only on 44; rd_ptr=4; frames_pending returns to 0.
- Backpressure:
  - Stimulus: same frame, with tx_ready toggling 1,0,0,1,…
  - Required: byte order preserved; tx_data stable while stalled; never more than 2 reads outstanding plus buffered; rd_ptr=4 at end.
- Wrap and back-to-back:
  - Stimulus: frame A at 2046..2047,0 (3 bytes); frame B 1 byte at 1 (0x1AA); two commits on consecutive cycles.
  - Required: A streamed contiguously across the wrap, then B (AA, tx_last=1); speculative read past A's EOF discarded (no duplicated/missing byte); rd_ptr=2.
- Counter saturation / simultaneous events:
  - Stimulus: 31 commits with tx_ready=0, a 32nd commit, then a commit on the same cycle as a last-byte handshake.
  - Required: 32nd commit → commit_ovf pulse, frames_pending stays 31; simultaneous commit+last → frames_pending unchanged.
- Reset mid-frame:
  - Stimulus: rst asserted after 2 of 4 bytes are accepted.
  - Required: tx_valid=0 and rd_ptr=0 immediately; after release, no stream until a new commit.
